rect_plotter: RTL

Rectangle fill engine that drives the pixel-write port of `vga_adapter` (`x`, `y`, `colour`, `plot`) at 160x120 resolution. It accepts one rectangle command at a time from the game FSMs (paddle draw/erase, ball draw/erase, screen clear) and emits one pixel write per clock in raster order. Pixels that fall off-screen are clipped. A `start`/`busy`/`done` handshake lets the caller sequence multiple objects through the single VGA write port.

---
 rtl/rect_plotter_if.sv | 26 ++
 rtl/rect_plotter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rect_plotter_if.sv
// Pixel-command bus between a game FSM (master) and rect_plotter (slave):
// rectangle command with start strobe, plus status and the VGA pixel-write port.
interface rect_plotter_if;
  logic       start;
  logic [7:0] rectX;
  logic [6:0] rectY;
  logic [7:0] rectW;
  logic [6:0] rectH;
  logic [2:0] rectColour;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output start, rectX, rectY, rectW, rectH, rectColour,
    input  busy, done, x, y, colour, plot
  );

  modport slave (
    input  start, rectX, rectY, rectW, rectH, rectColour,
    output busy, done, x, y, colour, plot
  );
endinterface

// File: rtl/rect_plotter.sv
// Rectangle fill engine: emits one clipped pixel write per clock in raster
// order into the vga_adapter write port, with a start/busy/done handshake.
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic           clock,
  input logic           reset,
  rect_plotter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

  logic [1:0] state_q, state_d;
  logic       hold_q, hold_d;
  logic [7:0] x0_q, x0_d;
  logic [6:0] y0_q, y0_d;
  logic [7:0] w_q, w_d;
  logic [6:0] h_q, h_d;
  logic [2:0] col_q, col_d;
  logic [7:0] i_q, i_d;
  logic [6:0] j_q, j_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       col_last;
  logic       row_last;

  // Widened sums so off-screen pixels are detected instead of wrapping.
  assign x_sum    = {1'b0, x0_q} + {1'b0, i_q};
  assign y_sum    = {1'b0, y0_q} + {1'b0, j_q};
  assign col_last = (i_q == w_q - 8'd1);
  assign row_last = (j_q == h_q - 7'd1);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would infer a latch.
    state_d  = state_q;
    hold_d   = hold_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    i_d      = i_q;
    j_d      = j_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x0_d  = bus.rectX;
          y0_d  = bus.rectY;
          w_d   = bus.rectW;
          h_d   = bus.rectH;
          col_d = bus.rectColour;
          i_d   = 8'd0;
          j_d   = 7'd0;
          if (bus.rectW == 8'd0 || bus.rectH == 7'd0) begin
            // Empty command spends one extra cycle in FIN so done lands at N+2.
            state_d = S_FIN;
            hold_d  = 1'b1;
          end else begin
            state_d = S_DRAW;
          end
        end
      end
      S_DRAW: begin
        x_d      = x_sum[7:0];
        y_d      = y_sum[6:0];
        colour_d = col_q;
        plot_d   = (x_sum < X_LIMIT) && (y_sum < Y_LIMIT);
        busy_d   = 1'b1;
        if (col_last) begin
          i_d = 8'd0;
          j_d = j_q + 7'd1;
          if (row_last) state_d = S_FIN;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      S_FIN: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hold_q   <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      i_q      <= i_d;
      j_q      <= j_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
